// File: rtl/armleocpu_tlb.sv
// Set-associative Sv32 TLB. Entries live in flops, and each set has its own
// round-robin victim pointer. A lookup result is registered one cycle after RESOLVE.
module armleocpu_tlb #(
   parameter int ENTRIES_W = 4,
   parameter int WAYS      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  cmd,
   input  logic [19:0] vaddr_input,
   input  logic [7:0]  accesstag_w,
   input  logic [21:0] phys_w,
   output logic        resolve_done,
   output logic        resolve_hit,
   output logic [7:0]  resolve_access_bits,
   output logic [21:0] resolve_physical_address
);

   localparam int SETS  = 1 << ENTRIES_W;
   localparam int TAG_W = 20 - ENTRIES_W;
   localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   localparam logic [1:0] CMD_NONE       = 2'd0;
   localparam logic [1:0] CMD_RESOLVE    = 2'd1;
   localparam logic [1:0] CMD_WRITE      = 2'd2;
   localparam logic [1:0] CMD_INVALIDATE = 2'd3;

   logic [WAYS-1:0]  valid_q  [SETS];
   logic [TAG_W-1:0] tag_q    [SETS][WAYS];
   logic [7:0]       acc_q    [SETS][WAYS];
   logic [21:0]      phys_q   [SETS][WAYS];
   logic [PTR_W-1:0] victim_q [SETS];

   logic        done_q, done_d;
   logic        hit_q, hit_d;
   logic [7:0]  acc_out_q, acc_out_d;
   logic [21:0] phys_out_q, phys_out_d;

   logic [ENTRIES_W-1:0] idx;
   logic [TAG_W-1:0]     tag;
   logic [WAYS-1:0]      match;
   logic                 any_match;
   logic                 any_free;
   logic [PTR_W-1:0]     hit_way;
   logic [PTR_W-1:0]     free_way;
   logic [PTR_W-1:0]     wr_way;
   logic                 use_victim;
   logic [PTR_W-1:0]     victim_nxt;

   assign idx = vaddr_input[ENTRIES_W-1:0];
   assign tag = vaddr_input[19:ENTRIES_W];

   // Descending scans, so the lowest-numbered matching or free way wins
   always_comb begin
      match    = '0;
      hit_way  = '0;
      free_way = '0;
      any_free = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         match[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (match[w]) begin
            hit_way = PTR_W'(w);
         end
         if (!valid_q[idx][w]) begin
            free_way = PTR_W'(w);
            any_free = 1'b1;
         end
      end
   end

   assign any_match  = |match;
   assign use_victim = !any_match && !any_free;
   assign wr_way     = any_match ? hit_way : (any_free ? free_way : victim_q[idx]);
   assign victim_nxt = (victim_q[idx] == PTR_W'(WAYS - 1)) ? '0 : victim_q[idx] + PTR_W'(1);

   always_comb begin
      done_d     = 1'b0;
      hit_d      = 1'b0;
      acc_out_d  = acc_out_q;
      phys_out_d = phys_out_q;
      if (cmd == CMD_RESOLVE) begin
         done_d = 1'b1;
         hit_d  = any_match;
         if (any_match) begin
            acc_out_d  = acc_q[idx][hit_way];
            phys_out_d = phys_q[idx][hit_way];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_q     <= 1'b0;
         hit_q      <= 1'b0;
         acc_out_q  <= '0;
         phys_out_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s]  <= '0;
            victim_q[s] <= '0;
         end
      end else begin
         done_q     <= done_d;
         hit_q      <= hit_d;
         acc_out_q  <= acc_out_d;
         phys_out_q <= phys_out_d;
         case (cmd)
            CMD_WRITE: begin
               valid_q[idx][wr_way] <= 1'b1;
               if (use_victim) begin
                  victim_q[idx] <= victim_nxt;
               end
            end
            CMD_INVALIDATE: begin
               for (int s = 0; s < SETS; s++) begin
                  valid_q[s]  <= '0;
                  victim_q[s] <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Tag and data storage is not reset. Only the valid bits qualify it.
   always_ff @(posedge clk) begin
      if (!rst && cmd == CMD_WRITE) begin
         tag_q[idx][wr_way]  <= tag;
         acc_q[idx][wr_way]  <= accesstag_w;
         phys_q[idx][wr_way] <= phys_w;
      end
   end

   assign resolve_done             = done_q;
   assign resolve_hit              = hit_q;
   assign resolve_access_bits      = acc_out_q;
   assign resolve_physical_address = phys_out_q;

endmodule

// File: tb/tb_armleocpu_tlb.sv
// Scoreboard bench for armleocpu_tlb (ENTRIES_W=4, WAYS=2). Directed commands
// queue their expected lookup results, and a monitor checks every done pulse.
module tb_armleocpu_tlb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  cmd = 2'd0;
   logic [19:0] vaddr_input = '0;
   logic [7:0]  accesstag_w = '0;
   logic [21:0] phys_w = '0;
   logic        resolve_done;
   logic        resolve_hit;
   logic [7:0]  resolve_access_bits;
   logic [21:0] resolve_physical_address;

   armleocpu_tlb #(.ENTRIES_W(4), .WAYS(2)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .cmd                      (cmd),
      .vaddr_input              (vaddr_input),
      .accesstag_w              (accesstag_w),
      .phys_w                   (phys_w),
      .resolve_done             (resolve_done),
      .resolve_hit              (resolve_hit),
      .resolve_access_bits      (resolve_access_bits),
      .resolve_physical_address (resolve_physical_address)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [30:0] exp_q [$];
   logic [7:0]  last_acc = '0;
   logic [21:0] last_phys = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wr(input logic [19:0] vpn, input logic [7:0] acc, input logic [21:0] ph);
      @(negedge clk);
      cmd = 2'd2; vaddr_input = vpn; accesstag_w = acc; phys_w = ph;
   endtask

   // A miss keeps the previous data outputs, so the model tracks them
   task automatic rs(input logic [19:0] vpn, input logic hit, input logic [7:0] acc, input logic [21:0] ph);
      @(negedge clk);
      cmd = 2'd1; vaddr_input = vpn;
      if (hit) begin
         last_acc  = acc;
         last_phys = ph;
      end
      exp_q.push_back({hit, last_acc, last_phys});
   endtask

   task automatic inv();
      @(negedge clk);
      cmd = 2'd3;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      cmd = 2'd0;
      repeat (n - 1) @(negedge clk);
   endtask

   always @(negedge clk) begin
      logic [30:0] e;
      if (resolve_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1, expected no pulse at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("resolve_hit", {31'd0, resolve_hit}, {31'd0, e[30]});
            chk("resolve_access_bits", {24'd0, resolve_access_bits}, {24'd0, e[29:22]});
            chk("resolve_physical_address", {10'd0, resolve_physical_address}, {10'd0, e[21:0]});
         end
      end else if (resolve_hit !== 1'b0) begin
         chk("hit_without_done", {31'd0, resolve_hit}, 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_done", {31'd0, resolve_done}, 32'd0);
      chk("reset_hit", {31'd0, resolve_hit}, 32'd0);
      chk("reset_acc", {24'd0, resolve_access_bits}, 32'd0);
      chk("reset_phys", {10'd0, resolve_physical_address}, 32'd0);
      rst = 1'b0;

      rs(20'h00013, 1'b0, 8'h00, 22'h0);
      wr(20'h00013, 8'hCF, 22'h000155);
      rs(20'h00013, 1'b1, 8'hCF, 22'h000155);
      rs(20'h00023, 1'b0, 8'h00, 22'h0);

      inv();
      wr(20'h00013, 8'hA1, 22'h000101);
      wr(20'h00023, 8'hA2, 22'h000102);
      wr(20'h00033, 8'hA3, 22'h000103);
      rs(20'h00013, 1'b0, 8'h00, 22'h0);
      rs(20'h00023, 1'b1, 8'hA2, 22'h000102);
      rs(20'h00033, 1'b1, 8'hA3, 22'h000103);
      wr(20'h00043, 8'hA4, 22'h000104);
      rs(20'h00023, 1'b0, 8'h00, 22'h0);
      rs(20'h00043, 1'b1, 8'hA4, 22'h000104);
      rs(20'h00033, 1'b1, 8'hA3, 22'h000103);
      wr(20'h00053, 8'hA5, 22'h000105);
      rs(20'h00033, 1'b0, 8'h00, 22'h0);
      rs(20'h00043, 1'b1, 8'hA4, 22'h000104);
      rs(20'h00053, 1'b1, 8'hA5, 22'h000105);

      inv();
      wr(20'h00013, 8'h0F, 22'h000001);
      wr(20'h00013, 8'h1F, 22'h000002);
      wr(20'h00023, 8'h2E, 22'h000003);
      rs(20'h00013, 1'b1, 8'h1F, 22'h000002);
      rs(20'h00023, 1'b1, 8'h2E, 22'h000003);

      inv();
      wr(20'h00013, 8'hC1, 22'h3FFFFF);
      wr(20'h00014, 8'hC2, 22'h000200);
      wr(20'h00005, 8'hC3, 22'h000300);
      wr(20'h00023, 8'hC4, 22'h000400);
      wr(20'h00033, 8'hC5, 22'h000500);
      rs(20'h00014, 1'b1, 8'hC2, 22'h000200);
      rs(20'h00005, 1'b1, 8'hC3, 22'h000300);
      rs(20'h00013, 1'b0, 8'h00, 22'h0);
      rs(20'h00023, 1'b1, 8'hC4, 22'h000400);
      rs(20'h00033, 1'b1, 8'hC5, 22'h000500);
      inv();
      rs(20'h00013, 1'b0, 8'h00, 22'h0);
      rs(20'h00014, 1'b0, 8'h00, 22'h0);
      rs(20'h00005, 1'b0, 8'h00, 22'h0);
      rs(20'h00023, 1'b0, 8'h00, 22'h0);
      rs(20'h00033, 1'b0, 8'h00, 22'h0);
      wr(20'h00033, 8'hD1, 22'h000601);
      wr(20'h00043, 8'hD2, 22'h000602);
      wr(20'h00053, 8'hD3, 22'h000603);
      rs(20'h00033, 1'b0, 8'h00, 22'h0);
      rs(20'h00043, 1'b1, 8'hD2, 22'h000602);
      rs(20'h00053, 1'b1, 8'hD3, 22'h000603);

      wr(20'hFFFFF, 8'hE1, 22'h3FFFFF);
      rs(20'h0000F, 1'b0, 8'h00, 22'h0);
      rs(20'hFFFFF, 1'b1, 8'hE1, 22'h3FFFFF);
      idle(3);

      @(negedge clk);
      rst = 1'b1; cmd = 2'd1; vaddr_input = 20'h00043;
      @(negedge clk);
      rst = 1'b0; cmd = 2'd0;
      last_acc  = '0;
      last_phys = '0;
      idle(2);
      rs(20'h00043, 1'b0, 8'h00, 22'h0);
      rs(20'hFFFFF, 1'b0, 8'h00, 22'h0);
      idle(4);

      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/armleocpu_tlb.md
# armleocpu_tlb

Set-associative translation lookaside buffer for the Sv32 MMU, sitting directly upstream of armleocpu_ptw. The cache/fetch controller looks up a virtual page number here first. On a miss it runs the page table walker, and it writes the walker's leaf result (access bits plus physical page number) back into this block. Invalidate-all serves SFENCE.VMA and SATP writes.

## Interface
Parameters:
- ENTRIES_W, 4 — set index width; 2^ENTRIES_W sets, index = vpn[ENTRIES_W-1:0].
- WAYS, 2 — ways per set, 1..4.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd  in  2  command: 0 NONE, 1 RESOLVE, 2 WRITE, 3 INVALIDATE.
- vaddr_input  in  20  VPN (virtual address [31:12]) for RESOLVE/WRITE.
- accesstag_w  in  8  access bits to store on WRITE (D A G U X W R V).
- phys_w  in  22  PPN to store on WRITE.
  - Stored verbatim.
  - For megapages the caller merges vpn[9:0] into the PPN before writing.
- resolve_done  out  1  one-cycle pulse, cycle after RESOLVE.
- resolve_hit  out  1  lookup matched a valid entry; meaningful only with resolve_done.
- resolve_access_bits  out  8  stored access bits of the hit entry.
- resolve_physical_address  out  22  stored PPN of the hit entry.

## Operation
- Storage in flops, per set and way:
  - valid bit.
  - tag = vpn[19:ENTRIES_W] (20-ENTRIES_W bits).
  - 8-bit access tag and 22-bit PPN.
- Each set has a round-robin victim pointer, width clog2(WAYS), min 1.
- RESOLVE:
  - Index the set and compare the tag against all valid ways.
  - Register the result:
    - resolve_done=1.
    - resolve_hit = any match.
    - On hit, data outputs = matching way.
    - On miss, data outputs hold their previous values.
- WRITE, way selection into set index, in priority order:
  - (a) a valid way whose tag matches (overwrite, no duplicate);
  - (b) else lowest-numbered invalid way;
  - (c) else the way at the victim pointer.
- WRITE stores tag, accesstag_w and phys_w, and sets valid.
- Victim pointer advances (mod WAYS) only when case (c) is used.
- accesstag_w[0]==0 (V clear) is still written; the entry is marked valid. Filtering faults is the caller's job.
- INVALIDATE clears every valid bit and resets every victim pointer to 0. Tags and data are untouched.
- NONE: no state change; resolve_done=0.
- At most one command per cycle by encoding, so no same-cycle conflicts exist.

## Timing
- Reset values (outputs and state, after rst high at a clock edge):
  - resolve_done=0, resolve_hit=0.
  - resolve_access_bits=0, resolve_physical_address=0.
  - All valid bits 0, all victim pointers 0.
- rst has priority over cmd. A command in the reset cycle is dropped, and a RESOLVE issued before reset produces no done after it.
- RESOLVE at edge N → resolve_done/hit/data stable after edge N+1, for exactly one cycle (done and hit return to 0 next cycle unless another RESOLVE).
- Back-to-back RESOLVEs: one result per cycle, fully pipelined.
- Lookup sees state as of before its own edge:
  - WRITE at N then RESOLVE at N+1 → hit.
  - INVALIDATE at N then RESOLVE at N+1 → miss.
- Victim pointer wraps WAYS-1 → 0.
- Index and tag split is exact; entries in different sets never interact.

## Test plan
- Reset, then RESOLVE vpn 0x00013 → next cycle resolve_done=1, resolve_hit=0, data outputs 0.
- WRITE vpn 0x00013, accesstag 0xCF, phys 0x000155; next cycle RESOLVE vpn 0x00013 → done=1, hit=1, access_bits 0xCF, physical 0x000155. RESOLVE vpn 0x00023 (same set, different tag) → hit=0.
- With WAYS=2, ENTRIES_W=4:
  - WRITE vpns 0x00013, 0x00023, 0x00033 (all set 3).
  - RESOLVE 0x00013 → miss (evicted, way 0).
  - RESOLVE 0x00023 and 0x00033 → hit.
  - A fourth write 0x00043 evicts way 1 (0x00023).
- WRITE vpn 0x00013 phys 0x1, then WRITE vpn 0x00013 phys 0x2, then WRITE 0x00023 → RESOLVE 0x00013 hits with phys 0x2. 0x00023 also hits, proving no duplicate consumed a way.
- Fill several sets, INVALIDATE, RESOLVE each VPN → all hit=0. A subsequent WRITE in a full-before set lands in way 0.
- Issue RESOLVE with rst asserted on the same edge → no resolve_done pulse afterwards; earlier-written entries miss.
